// File: rtl/instrumented_adder_seq.sv
// instrumented_adder_seq: measurement sequencer for the instrumented adder (load operands/masks, settle, gate loop, count chain_out rising edges, flush, return count via valid/ack); ports: wb_clk_i/wb_rst_i clock and async reset, start plus *_cfg config inputs, chain_out loop return, adder drive outputs a_input/b_input/masks/loop_en, status busy, result handshake result_valid/result_ack/result/overflow/timeout; optional INSTR_SEQ_TIMEOUT_EN adds a no-edge abort
module instrumented_adder_seq #(
  parameter int CNT_W          = 24,
  parameter int GATE_W         = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int FLUSH_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [31:0]       a_cfg,
  input  logic [31:0]       b_cfg,
  input  logic [31:0]       ext_mask_cfg,
  input  logic [31:0]       ring_mask_cfg,
  input  logic [31:0]       s_sel_cfg,
  input  logic [GATE_W-1:0] gate_cfg,
  input  logic              chain_out,
  input  logic              result_ack,
  output logic [31:0]       a_input,
  output logic [31:0]       b_input,
  output logic [31:0]       a_input_ext_bit_b,
  output logic [31:0]       a_input_ring_bit_b,
  output logic [31:0]       s_output_bit_b,
  output logic              loop_en,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  result,
  output logic              overflow,
  output logic              timeout
);
`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, FLUSH, DONE} state_t;
  state_t             state_q, state_d;
  logic [31:0]        a_q, b_q, ext_q, ring_q, ssel_q;
  logic [GATE_W-1:0]  gate_q, tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, res_q, res_d;
  logic               ovf_q, ovf_d, valid_q, valid_d, to_q, to_d, loop_q;
  logic [2:0]         sync_q;
  logic               ld, rise, to_hit;
  assign ld   = (state_q == IDLE) && start;
  assign rise = sync_q[1] & ~sync_q[2];
  // abort on the last cycle of the no-edge window, only when the gate is longer than that window
  assign to_hit = TO_EN && (state_q == RUN) && (gate_q > GATE_W'(TIMEOUT_CYCLES)) && (cnt_q == '0) && !ovf_q && !rise
                  && (tmr_q == gate_q - GATE_W'(TIMEOUT_CYCLES));
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    valid_d = valid_q;
    to_d    = to_q;
    // edges still draining through the synchronizer during FLUSH are counted
    if ((state_q == RUN || state_q == FLUSH) && rise) begin
      if (&cnt_q) ovf_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        to_d    = 1'b0;
      end
      LOAD: begin
        state_d = SETTLE;
        tmr_d   = GATE_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (tmr_q == '0) begin
        state_d = RUN;
        tmr_d   = gate_q - 1'b1;
      end else tmr_d = tmr_q - 1'b1;
      RUN: if (tmr_q == '0 || to_hit) begin
        state_d = FLUSH;
        tmr_d   = GATE_W'(FLUSH_CYCLES - 1);
        to_d    = to_hit;
      end else tmr_d = tmr_q - 1'b1;
      FLUSH: if (tmr_q == '0) begin
        state_d = DONE;
        res_d   = to_q ? '0 : cnt_d;
        valid_d = 1'b1;
      end else tmr_d = tmr_q - 1'b1;
      // valid drops on ack while staying in DONE one more cycle, so busy falls a cycle later
      DONE: if (!valid_q) state_d = IDLE;
            else if (result_ack) valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ext_q   <= '0;
      ring_q  <= '0;
      ssel_q  <= 32'h0000_01FF;
      gate_q  <= GATE_W'(1);
      tmr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      loop_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      loop_q  <= (state_d == RUN);
      sync_q  <= {sync_q[1:0], chain_out};
      if (ld) begin
        a_q    <= a_cfg;
        b_q    <= b_cfg;
        ext_q  <= ext_mask_cfg;
        ring_q <= ring_mask_cfg;
        ssel_q <= s_sel_cfg;
        gate_q <= (gate_cfg == '0) ? GATE_W'(1) : gate_cfg;
      end
    end
  end
  assign a_input            = a_q;
  assign b_input            = b_q;
  assign a_input_ext_bit_b  = ext_q;
  assign a_input_ring_bit_b = ring_q;
  assign s_output_bit_b     = ssel_q;
  assign loop_en            = loop_q;
  assign busy               = (state_q != IDLE);
  assign result_valid       = valid_q;
  assign result             = res_q;
  assign overflow           = ovf_q;
  assign timeout            = TO_EN ? to_q : 1'b0;
endmodule
